// File: rtl/gf2_polydiv21.sv
// Bit-serial GF(2) polynomial divider: dividend = quotient*divisor ^ remainder.
// Normalises the divisor to the top of the word, then retires one quotient bit per cycle.
module gf2_polydiv21 #(
    parameter int unsigned NA = 21,
    parameter int unsigned NB = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NA-1:0] dividend,
    input  logic [NB-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NA-1:0] quotient,
    output logic [NB-2:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned PW = $clog2(NA);
    localparam int unsigned SH = NA - NB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [NA-1:0]   r_rem;
    logic [NA-1:0]   r_den;
    logic [NA-1:0]   r_quo;
    logic [PW-1:0]   r_pos;
    logic [PW-1:0]   r_dg;
    logic            r_dbz;
    logic [PW-1:0]   w_qidx;

    assign w_qidx = r_pos - r_dg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        w_next = S_DONE;
                    end else if (divisor[NB-1]) begin
                        w_next = S_DIV;
                    end else begin
                        w_next = S_NORM;
                    end
                end
            end
            S_NORM: begin
                if (r_den[NA-2]) begin
                    w_next = S_DIV;
                end
            end
            S_DIV: begin
                if (r_pos == r_dg) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath: dg counts down while the divisor is shifted up to bit NA-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_den <= '0;
            r_quo <= '0;
            r_pos <= '0;
            r_dg  <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_den <= NA'(divisor) << SH;
                        r_quo <= '0;
                        r_dg  <= PW'(NB - 1);
                        r_pos <= PW'(NA - 1);
                        if (divisor == '0) begin
                            r_rem <= '0;
                            r_dbz <= 1'b1;
                        end else begin
                            r_rem <= dividend;
                        end
                    end
                end
                S_NORM: begin
                    r_den <= r_den << 1;
                    r_dg  <= r_dg - PW'(1);
                    r_pos <= PW'(NA - 1);
                end
                S_DIV: begin
                    if (r_rem[r_pos]) begin
                        r_rem         <= r_rem ^ r_den;
                        r_quo[w_qidx] <= 1'b1;
                    end
                    r_den <= r_den >> 1;
                    r_pos <= r_pos - PW'(1);
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quo;
    assign remainder   = r_rem[NB-2:0];
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_gf2_polydiv21.sv
// Scoreboard bench for gf2_polydiv21: directed corner cases, reset abort,
// and random multiplier-product round trips with optional remainder.
module tb_gf2_polydiv21;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [20:0] dividend = '0;
    logic [10:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [20:0] quotient;
    logic [9:0]  remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [20:0] q;
        logic [9:0]  r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    gf2_polydiv21 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] clmul(input logic [10:0] a, input logic [10:0] b);
        logic [20:0] p = '0;
        for (int i = 0; i < 11; i++) begin
            if (b[i]) p = p ^ (21'(a) << i);
        end
        return p;
    endfunction

    function automatic int deg(input logic [10:0] b);
        int d = 0;
        for (int i = 0; i < 11; i++) begin
            if (b[i]) d = i;
        end
        return d;
    endfunction

    // One division: drive, push expectation, wait bounded, pop and compare, optional hold
    task automatic run_op(input logic [20:0] dvd, input logic [10:0] dvs,
                          input logic [20:0] eq, input logic [9:0] er, input logic edz,
                          input int elat, input int hold);
        exp_t e;
        int lat;
        logic [20:0] q0;
        logic [9:0]  r0;
        e.q = eq; e.r = er; e.dz = edz; e.lat = elat;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 21'($urandom);
        divisor  = 11'($urandom);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("latency", 32'(lat), 32'(e.lat));
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("dbz", 32'(div_by_zero), 32'(e.dz));
        chk("busy_ready", 32'(in_ready), 32'd0);
        q0 = quotient;
        r0 = remainder;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = 21'($urandom);
            divisor  = 11'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_q", 32'(quotient), 32'(q0));
            chk("hold_r", 32'(remainder), 32'(r0));
            chk("hold_dbz", 32'(div_by_zero), 32'(e.dz));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_ready", 32'(in_ready), 32'd1);
        chk("post_dbz", 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        logic [10:0] a;
        logic [10:0] b;
        logic [9:0]  r;
        int db;

        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(21'h000400, 11'h400, 21'h000001, 10'h000, 1'b0, 11, 0);
        run_op(21'h00000B, 11'h007, 21'h000003, 10'h002, 1'b0, 27, 0);
        run_op(21'h1FFFFF, 11'h001, 21'h1FFFFF, 10'h000, 1'b0, 31, 0);
        run_op(21'h000005, 11'h400, 21'h000000, 10'h005, 1'b0, 11, 0);
        run_op(21'h012345, 11'h000, 21'h000000, 10'h000, 1'b1, 0, 5);

        // Abort a division mid-DIV with an asynchronous reset
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 21'h0ABCDE;
        divisor  = 11'h003;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(21'h000400, 11'h400, 21'h000001, 10'h000, 1'b0, 11, 0);

        // Multiplier round trip, odd iterations add a remainder of lower degree
        for (int it = 0; it < 1000; it++) begin
            a = 11'($urandom);
            b = 11'($urandom);
            if (b == '0) b = 11'h001;
            db = deg(b);
            r = '0;
            if ((it % 2) == 1 && db > 0) begin
                r = 10'($urandom) & 10'((1 << db) - 1);
                if (r == '0) r = 10'h001;
            end
            run_op(clmul(a, b) ^ 21'(r), b, 21'(a), r, 1'b0, 31 - 2 * db,
                   ((it % 97) == 0) ? 2 : 0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
